// File: rtl/ifetch_if.sv
// Fetch-stage bundle: icache request/response, decode handshake and redirect inputs.
// master = fetch stage, slave = environment (icache + decode + commit).
interface ifetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  icache_req;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic                  icache_valid;
  logic [INST_WIDTH-1:0] icache_inst;
  logic                  if2dec;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [INST_WIDTH-1:0] inst_out;
  logic                  dec_ready;
  logic                  decFlush;
  logic [ADDR_WIDTH-1:0] dec2if;
  logic                  rob_flush;
  logic [ADDR_WIDTH-1:0] rob_target;

  modport master (
    output icache_req, icache_addr, if2dec, pc_out, inst_out,
    input  icache_valid, icache_inst, dec_ready, decFlush, dec2if, rob_flush, rob_target
  );

  modport slave (
    input  icache_req, icache_addr, if2dec, pc_out, inst_out,
    output icache_valid, icache_inst, dec_ready, decFlush, dec2if, rob_flush, rob_target
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding icache request at a time, responses buffered
// in a DEPTH-entry FIFO whose head is offered to decode; redirects flush everything.
module ifetch #(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  INST_WIDTH = 32,
  parameter int                  QUEUE_LOG  = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0
) (
  input  logic     clk,
  input  logic     rst_in,
  input  logic     rdy_in,
  ifetch_if.master bus
);
  localparam int DEPTH = 1 << QUEUE_LOG;
  localparam logic [QUEUE_LOG:0]    DEPTH_C  = {1'b1, {QUEUE_LOG{1'b0}}};
  localparam logic [QUEUE_LOG:0]    CNT_ZERO = {(QUEUE_LOG+1){1'b0}};
  localparam logic [QUEUE_LOG:0]    CNT_ONE  = (QUEUE_LOG+1)'(1'b1);
  localparam logic [QUEUE_LOG-1:0]  PTR_ZERO = {QUEUE_LOG{1'b0}};
  localparam logic [QUEUE_LOG-1:0]  PTR_ONE  = QUEUE_LOG'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(3'd4);
  localparam logic [INST_WIDTH-1:0] INST_ZERO = {INST_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  req_r;
  logic [QUEUE_LOG-1:0]  head_r;
  logic [QUEUE_LOG-1:0]  tail_r;
  logic [QUEUE_LOG:0]    count_r;
  logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_r [DEPTH];

  logic                  flush_s;
  logic [ADDR_WIDTH-1:0] target_s;
  logic                  deq_s;
  logic                  enq_s;
  logic [QUEUE_LOG:0]    count_next_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s;

  // Redirect selection and next-occupancy computation
  always_comb begin
    flush_s = bus.rob_flush | bus.decFlush;
    if (bus.rob_flush) begin
      target_s = bus.rob_target;
    end else begin
      target_s = bus.dec2if;
    end
    deq_s        = (count_r != CNT_ZERO) && bus.dec_ready;
    enq_s        = (state_r == WAIT) && bus.icache_valid;
    count_next_s = count_r + (enq_s ? CNT_ONE : CNT_ZERO) - (deq_s ? CNT_ONE : CNT_ZERO);
    pc_inc_s     = pc_r + PC_STEP;
  end

  assign bus.icache_req  = req_r;
  assign bus.icache_addr = addr_r;
  assign bus.if2dec      = (count_r != CNT_ZERO);
  assign bus.pc_out      = pc_mem_r[head_r];
  assign bus.inst_out    = inst_mem_r[head_r];

  // Fetch FSM, PC and FIFO state
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= ADDR_ZERO;
      req_r   <= 1'b0;
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= ADDR_ZERO;
        inst_mem_r[i] <= INST_ZERO;
      end
    end else if (rdy_in) begin
      if (flush_s) begin
        head_r  <= PTR_ZERO;
        tail_r  <= PTR_ZERO;
        count_r <= CNT_ZERO;
        pc_r    <= target_s;
        // A request still in flight must have its response swallowed in DROP
        case (state_r)
          WAIT: begin
            if (bus.icache_valid) begin
              req_r   <= 1'b0;
              state_r <= IDLE;
            end else begin
              state_r <= DROP;
            end
          end
          DROP: begin
            if (bus.icache_valid) begin
              req_r   <= 1'b0;
              state_r <= IDLE;
            end
          end
          default: state_r <= IDLE;
        endcase
      end else begin
        if (deq_s) begin
          head_r <= head_r + PTR_ONE;
        end
        count_r <= count_next_s;
        case (state_r)
          IDLE: begin
            if (count_r < DEPTH_C) begin
              req_r   <= 1'b1;
              addr_r  <= pc_r;
              state_r <= WAIT;
            end
          end
          WAIT: begin
            if (bus.icache_valid) begin
              pc_mem_r[tail_r]   <= pc_r;
              inst_mem_r[tail_r] <= bus.icache_inst;
              tail_r             <= tail_r + PTR_ONE;
              pc_r               <= pc_inc_s;
              // Chain the next request on the same edge when the FIFO still has room
              if (count_next_s < DEPTH_C) begin
                addr_r <= pc_inc_s;
              end else begin
                req_r   <= 1'b0;
                state_r <= IDLE;
              end
            end
          end
          DROP: begin
            if (bus.icache_valid) begin
              req_r   <= 1'b0;
              state_r <= IDLE;
            end
          end
          default: begin
            req_r   <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: behavioural icache with programmable latency and
// a scoreboard queue of expected {pc, inst} entries compared at the decode port.
module tb_ifetch;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic clk    = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  ifetch_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

  ifetch #(.ADDR_WIDTH(32), .INST_WIDTH(32), .QUEUE_LOG(2), .RESET_PC(32'h0)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  entry_t      sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat      = 1;
  int          wait_cnt = 0;
  logic        last_req = 1'b0;
  logic        fresh    = 1'b1;
  logic        drop     = 1'b0;
  logic [31:0] exp_pc   = 32'h0;
  logic        hit;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, update the model, check outputs.
  // fl: 0 none, 1 decFlush when a request is pending without a response,
  //     2 rob_flush + decFlush together with a response strobe.
  task automatic tick(input logic rdy, input logic rst, input logic dr, input int fl,
                      output logic did);
    entry_t e;
    did           = 1'b0;
    rdy_in        = rdy;
    rst_in        = rst;
    bus.dec_ready = dr;
    bus.icache_valid = 1'b0;
    bus.icache_inst  = 32'h0;
    if (rst && rdy && last_req) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        bus.icache_valid = 1'b1;
        bus.icache_inst  = bus.icache_addr ^ 32'hA5A5_0000;
      end
    end
    bus.decFlush  = 1'b0;
    bus.rob_flush = 1'b0;
    if (rst && rdy && fl == 1 && last_req && !bus.icache_valid) begin
      bus.decFlush = 1'b1;
      did = 1'b1;
    end
    if (rst && rdy && fl == 2 && bus.icache_valid) begin
      bus.decFlush  = 1'b1;
      bus.rob_flush = 1'b1;
      did = 1'b1;
    end

    @(posedge clk);
    #1;

    if (!rst) begin
      sb_q.delete();
      exp_pc   = 32'h0;
      drop     = 1'b0;
      wait_cnt = 0;
      fresh    = 1'b1;
    end else if (rdy) begin
      if (bus.decFlush || bus.rob_flush) begin
        if (bus.icache_valid) drop = 1'b0;
        else if (last_req) drop = 1'b1;
        sb_q.delete();
        exp_pc = bus.rob_flush ? bus.rob_target : bus.dec2if;
      end else begin
        if (sb_q.size() != 0 && dr) e = sb_q.pop_front();
        if (bus.icache_valid) begin
          if (drop) begin
            drop = 1'b0;
          end else begin
            e.pc   = exp_pc;
            e.inst = exp_pc ^ 32'hA5A5_0000;
            sb_q.push_back(e);
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
      if (bus.icache_valid) begin
        wait_cnt = 0;
        fresh    = 1'b1;
      end
    end

    check_val("if2dec", {31'b0, bus.if2dec}, {31'b0, (sb_q.size() != 0)});
    if (sb_q.size() != 0) begin
      check_val("pc_out", bus.pc_out, sb_q[0].pc);
      check_val("inst_out", bus.inst_out, sb_q[0].inst);
    end
    if (bus.icache_req) begin
      if (fresh) begin
        check_val("fetch_addr", bus.icache_addr, exp_pc);
        fresh = 1'b0;
      end
    end else begin
      fresh = 1'b1;
    end
    last_req = bus.icache_req;
  endtask

  task automatic run(input int n, input logic rdy, input logic dr);
    logic d;
    for (int i = 0; i < n; i++) tick(rdy, 1'b1, dr, 0, d);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_req", {31'b0, bus.icache_req}, 32'h0);
    check_val("rst_addr", bus.icache_addr, 32'h0);
    check_val("rst_if2dec", {31'b0, bus.if2dec}, 32'h0);
    check_val("rst_pc_out", bus.pc_out, 32'h0);
    check_val("rst_inst_out", bus.inst_out, 32'h0);
  endtask

  initial begin
    bus.icache_valid = 1'b0;
    bus.icache_inst  = 32'h0;
    bus.dec_ready    = 1'b0;
    bus.decFlush     = 1'b0;
    bus.rob_flush    = 1'b0;
    bus.dec2if       = 32'h100;
    bus.rob_target   = 32'h200;

    // Reset, then streaming with a 1-cycle icache
    tick(1'b1, 1'b0, 1'b1, 0, hit);
    tick(1'b1, 1'b0, 1'b1, 0, hit);
    check_reset_outputs();
    lat = 1;
    run(12, 1'b1, 1'b1);

    // Back-pressure fills the FIFO and stops fetching; then drain in order
    run(10, 1'b1, 1'b0);
    check_val("full_req_off", {31'b0, bus.icache_req}, 32'h0);
    check_val("full_if2dec", {31'b0, bus.if2dec}, 32'h1);
    run(10, 1'b1, 1'b1);

    // Decode redirect while a slow response is pending
    lat = 3;
    run(4, 1'b1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) tick(1'b1, 1'b1, 1'b1, 1, hit);
    check_val("dec_flush_hit", {31'b0, hit}, 32'h1);
    run(14, 1'b1, 1'b1);

    // Commit + decode redirect together with a response strobe: commit wins
    lat = 1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) tick(1'b1, 1'b1, 1'b1, 2, hit);
    check_val("rob_flush_hit", {31'b0, hit}, 32'h1);
    check_val("rob_flush_if2dec", {31'b0, bus.if2dec}, 32'h0);
    run(8, 1'b1, 1'b1);

    // Fill, freeze with rdy_in low, resume
    run(8, 1'b1, 1'b0);
    run(5, 1'b0, 1'b1);
    check_val("frozen_if2dec", {31'b0, bus.if2dec}, 32'h1);
    run(10, 1'b1, 1'b1);

    // Reset in the middle of a pending request
    lat = 2;
    for (int i = 0; i < 20 && !last_req; i++) tick(1'b1, 1'b1, 1'b1, 0, hit);
    check_val("pre_rst_req", {31'b0, last_req}, 32'h1);
    tick(1'b1, 1'b0, 1'b1, 0, hit);
    check_reset_outputs();
    tick(1'b1, 1'b1, 1'b1, 0, hit);
    check_val("post_rst_req", {31'b0, bus.icache_req}, 32'h1);
    check_val("post_rst_addr", bus.icache_addr, 32'h0);
    run(10, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
